// File: rtl/regfile_mp_pkg.sv
// Shared CPU constants and types used by the register file and its scoreboard.
package regfile_mp_pkg;

    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned CPU_NREGS  = 32;
    localparam int unsigned CPU_ADDR_W = $clog2(CPU_NREGS);

    typedef logic [CPU_ADDR_W-1:0] regAddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered population count.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NREGS    = CPU_NREGS,
    parameter int unsigned ADDR_W   = $clog2(NREGS),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             setEff, incCnt, decCnt;

    assign setEff = sb_set && !(ZERO_REG && sb_addr == '0);

    always_comb begin
        busy_d = busy_q;
        if (reg_write) busy_d[wrAddr] = 1'b0;
        // Applied after the clear so a same-address issue keeps the register pending.
        if (setEff) busy_d[sb_addr] = 1'b1;
    end

    // Incremental count avoids a full popcount tree; set-on-busy and set+clear same addr net 0.
    always_comb begin
        incCnt = setEff && !busy_q[sb_addr];
        decCnt = reg_write && busy_q[wrAddr] && !(setEff && sb_addr == wrAddr);
        cnt_d  = cnt_q + (ADDR_W+1)'(incCnt) - (ADDR_W+1)'(decCnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        busyA = busy_q[rdAddrA];
        busyB = busy_q[rdAddrB];
        if (BYPASS && reg_write && wrAddr == rdAddrA) busyA = 1'b0;
        if (BYPASS && reg_write && wrAddr == rdAddrB) busyB = 1'b0;
    end

    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Two-read one-write register file with optional write forwarding, hardwired r0
// and a pending-write scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W   = CPU_DATA_W,
    parameter int unsigned NREGS    = CPU_NREGS,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              weLive;
    logic              weStore;

    // Gated by reset so a write held during reset neither lands nor forwards.
    assign weLive  = reg_write && reset;
    assign weStore = weLive && !(ZERO_REG && wrAddr == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (weStore) begin
            regs_q[wrAddr] <= wrData;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] val;
        val = stored;
        if (BYPASS && weLive && wrAddr == addr) val = wrData;
        if (ZERO_REG && addr == '0) val = '0;
        return val;
    endfunction

    always_comb begin
        rdDataA = readPort(rdAddrA, regs_q[rdAddrA]);
        rdDataB = readPort(rdAddrB, regs_q[rdAddrB]);
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .reg_write (weLive),
        .wrAddr    (wrAddr),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .busyA     (busyA),
        .busyB     (busyB),
        .busy_cnt  (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; a BYPASS=0 instance shares the stimulus for forwarding checks.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  rdAddrA, rdAddrB;
    logic        sb_set;
    logic [4:0]  sb_addr;

    logic [31:0] rdDataA, rdDataB, rdDataA_nb, rdDataB_nb;
    logic        busyA, busyB, busyA_nb, busyB_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .NREGS(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA), .rdDataB(rdDataB),
        .sb_set(sb_set), .sb_addr(sb_addr), .busyA(busyA), .busyB(busyB), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.DATA_W(32), .NREGS(32), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_nb (
        .clk(clk), .reset(reset), .reg_write(reg_write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdDataA(rdDataA_nb), .rdDataB(rdDataB_nb),
        .sb_set(sb_set), .sb_addr(sb_addr), .busyA(busyA_nb), .busyB(busyB_nb),
        .busy_cnt(busy_cnt_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        sb_set    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); wrAddr = '0; wrData = '0; sb_addr = '0;
        rdAddrA = 5'd10; rdAddrB = 5'd15;
        #2;
        checks++; if (rdDataA !== 32'd0) begin failures++;
            $display("FAIL reset_rdA got=%0h exp=0", rdDataA); end
        checks++; if (busy_cnt !== 6'd0) begin failures++;
            $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
        @(posedge clk); @(posedge clk);
        @(negedge clk); reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        reg_write = 1'b1; wrAddr = 5'd10; wrData = 32'd23; tick();
        wrAddr = 5'd15; wrData = 32'd7; tick();
        idle(); rdAddrA = 5'd15; rdAddrB = 5'd10; #1;
        checks++; if (rdDataA !== 32'd7) begin failures++;
            $display("FAIL wr_rdA got=%0d exp=7", rdDataA); end
        checks++; if (rdDataB !== 32'd23) begin failures++;
            $display("FAIL wr_rdB got=%0d exp=23", rdDataB); end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF; rdAddrA = 5'd5; #1;
        checks++; if (rdDataA !== 32'hDEADBEEF) begin failures++;
            $display("FAIL bypass_fwd got=%0h exp=deadbeef", rdDataA); end
        checks++; if (rdDataA_nb !== 32'd0) begin failures++;
            $display("FAIL nobypass_old got=%0h exp=0", rdDataA_nb); end
        tick(); idle(); #1;
        checks++; if (rdDataA_nb !== 32'hDEADBEEF) begin failures++;
            $display("FAIL nobypass_after got=%0h exp=deadbeef", rdDataA_nb); end
    endtask

    task automatic test_zero_reg();
        reg_write = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF; rdAddrA = 5'd0; #1;
        checks++; if (rdDataA !== 32'd0) begin failures++;
            $display("FAIL zero_bypass got=%0h exp=0", rdDataA); end
        tick(); idle(); #1;
        checks++; if (rdDataA !== 32'd0) begin failures++;
            $display("FAIL zero_stored got=%0h exp=0", rdDataA); end
        sb_set = 1'b1; sb_addr = 5'd0; tick(); idle(); #1;
        checks++; if (busy_cnt !== 6'd0) begin failures++;
            $display("FAIL zero_sb_cnt got=%0d exp=0", busy_cnt); end
        checks++; if (busyA !== 1'b0) begin failures++;
            $display("FAIL zero_sb_busy got=%0b exp=0", busyA); end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_addr = 5'd3; tick();
        sb_addr = 5'd4; tick(); idle(); rdAddrA = 5'd3; #1;
        checks++; if (busy_cnt !== 6'd2) begin failures++;
            $display("FAIL sb_cnt2 got=%0d exp=2", busy_cnt); end
        checks++; if (busyA !== 1'b1) begin failures++;
            $display("FAIL sb_busy3 got=%0b exp=1", busyA); end
        reg_write = 1'b1; wrAddr = 5'd3; wrData = 32'd33; #1;
        checks++; if (busyA !== 1'b0) begin failures++;
            $display("FAIL sb_busy_fwd got=%0b exp=0", busyA); end
        checks++; if (busyA_nb !== 1'b1) begin failures++;
            $display("FAIL sb_busy_nofwd got=%0b exp=1", busyA_nb); end
        tick(); idle(); #1;
        checks++; if (busy_cnt !== 6'd1) begin failures++;
            $display("FAIL sb_cnt1 got=%0d exp=1", busy_cnt); end
        checks++; if (busyA !== 1'b0) begin failures++;
            $display("FAIL sb_busy3_clr got=%0b exp=0", busyA); end
    endtask

    task automatic test_same_addr();
        // r4 is still pending from the previous scenario.
        sb_set = 1'b1; sb_addr = 5'd6; reg_write = 1'b1; wrAddr = 5'd6; wrData = 32'd66;
        tick(); idle(); rdAddrA = 5'd6; #1;
        checks++; if (busyA !== 1'b1) begin failures++;
            $display("FAIL same_busy6 got=%0b exp=1", busyA); end
        checks++; if (busy_cnt !== 6'd2) begin failures++;
            $display("FAIL same_cnt got=%0d exp=2", busy_cnt); end
        sb_set = 1'b1; sb_addr = 5'd8; tick(); idle(); #1;
        checks++; if (busy_cnt !== 6'd3) begin failures++;
            $display("FAIL set8_cnt got=%0d exp=3", busy_cnt); end
        sb_set = 1'b1; sb_addr = 5'd7; reg_write = 1'b1; wrAddr = 5'd8; wrData = 32'd88;
        tick(); idle(); rdAddrA = 5'd7; rdAddrB = 5'd8; #1;
        checks++; if (busy_cnt !== 6'd3) begin failures++;
            $display("FAIL swap_cnt got=%0d exp=3", busy_cnt); end
        checks++; if (busyA !== 1'b1 || busyB !== 1'b0) begin failures++;
            $display("FAIL swap_busy got=%0b%0b exp=10", busyA, busyB); end
        sb_set = 1'b1; sb_addr = 5'd4; tick(); idle(); #1;
        checks++; if (busy_cnt !== 6'd3) begin failures++;
            $display("FAIL reset_busy_cnt got=%0d exp=3", busy_cnt); end
    endtask

    task automatic test_reset_mid();
        rdAddrA = 5'd9; rdAddrB = 5'd10;
        @(negedge clk);
        reset = 1'b0; reg_write = 1'b1; wrAddr = 5'd9; wrData = 32'd42;
        sb_set = 1'b1; sb_addr = 5'd9; #1;
        checks++; if (rdDataA !== 32'd0) begin failures++;
            $display("FAIL mid_rd9 got=%0d exp=0", rdDataA); end
        checks++; if (busy_cnt !== 6'd0) begin failures++;
            $display("FAIL mid_cnt got=%0d exp=0", busy_cnt); end
        checks++; if (rdDataB !== 32'd0) begin failures++;
            $display("FAIL mid_rd10 got=%0d exp=0", rdDataB); end
        tick();
        idle();
        @(negedge clk); reset = 1'b1; #1;
        checks++; if (rdDataA !== 32'd0) begin failures++;
            $display("FAIL post_rd9 got=%0d exp=0", rdDataA); end
        checks++; if (busy_cnt !== 6'd0) begin failures++;
            $display("FAIL post_cnt got=%0d exp=0", busy_cnt); end
        reg_write = 1'b1; wrAddr = 5'd9; wrData = 32'd42; tick(); idle(); #1;
        checks++; if (rdDataA !== 32'd42) begin failures++;
            $display("FAIL resume_rd9 got=%0d exp=42", rdDataA); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_same_addr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
